// File: rtl/bw_mac3_acc.sv
// Signed accumulator for a stream of 6-bit Baugh-Wooley products, one job of len terms at a time.
// Latency: result valid the cycle after the last accepted beat; zero-length jobs complete one cycle after start.
// Backpressure: in_ready only while accumulating; the result is held in DONE until out_ready.
module bw_mac3_acc #(
    parameter int LEN_W = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [5:0]       p_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [ACC_W-1:0] p_ext;
    logic             beat_acc;

    assign p_ext    = ACC_W'($signed(p_in));
    assign beat_acc = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ACC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            ACC: begin
                if (beat_acc) begin
                    // Wraps modulo 2^ACC_W by construction; no saturation.
                    acc_d = acc_q + p_ext;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake outputs depend on registered state only.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign acc_out   = acc_q;

endmodule
